hilo_commit_pipe: RTL and testbench
===================================

Name: hilo_commit_pipe

Overview:
- Receiving end of the execute stage's result and HI/LO write interface.
- Holds the EX/MEM and MEM/WB pipeline registers for destination, result and HI/LO fields.
- Owns the architectural HI and LO registers.
- Feeds back the mem_* and wb_* HI/LO forwarding buses and the committed hi/lo values that the execute stage consumes. Sits between execute and the register file.

Parameters:
- DATA_W, 32, width of GPR data and of HI/LO.
- ADDR_W, 5, width of GPR destination address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high (1 = RstEnable).
- stall_i  in  6  pipeline stall vector; bit3 = EX stage stopped, bit4 = MEM stage stopped, bit5 = WB stage stopped; 1 = stop.
- flush_i  in  1  pipeline flush; clears both stage registers.
- ex_wd_i  in  ADDR_W  execute destination register.
- ex_wreg_i  in  1  execute GPR write enable.
- ex_wdata_i  in  DATA_W  execute GPR result.
- ex_whilo_i  in  1  execute HI/LO write enable.
- ex_hi_i  in  DATA_W  execute HI value.
- ex_lo_i  in  DATA_W  execute LO value.
- mem_whilo_o  out  1  EX/MEM HI/LO write enable (forwarding).
- mem_hi_o  out  DATA_W  EX/MEM HI (forwarding).
- mem_lo_o  out  DATA_W  EX/MEM LO (forwarding).
- wb_whilo_o  out  1  MEM/WB HI/LO write enable (forwarding).
- wb_hi_o  out  DATA_W  MEM/WB HI (forwarding).
- wb_lo_o  out  DATA_W  MEM/WB LO (forwarding).
- rf_we_o  out  1  register file write enable.
- rf_waddr_o  out  ADDR_W  register file write address.
- rf_wdata_o  out  DATA_W  register file write data.
- hi_o  out  DATA_W  architectural HI.
- lo_o  out  DATA_W  architectural LO.

Behaviour:
- Reset: synchronous, active-high; rst is sampled only on the rising edge of clk.
  - rst=1 clears both stage registers, HI and LO to 0.
  - All outputs are 0 on the cycle after reset is sampled.
  - rst has priority over flush_i and stall_i.
  - Reset mid-operation discards in-flight instructions without committing them.
- EX/MEM register update priority (each clock):
  - rst or flush_i: clear.
  - stall_i[3]=1 and stall_i[4]=0: load bubble (all fields 0).
  - stall_i[3]=0: load ex_* inputs.
  - Otherwise: hold.
- MEM/WB register: same rule using stall_i[4]/stall_i[5], loading from EX/MEM.
- mem_* outputs: driven directly from the EX/MEM register.
- wb_* and rf_* outputs: driven from the MEM/WB register.
  - rf_we_o = MEM/WB wreg AND NOT stall_i[5].
- HI/LO commit: on a clock where MEM/WB whilo=1 and stall_i[5]=0, load HI/LO from MEM/WB hi/lo. HI and LO are always written together.
  - flush_i does not block this commit; the instruction in WB retires in the flush cycle.
- Latency:
  - ex_* appear on mem_* 1 cycle later and on wb_*/rf_* 2 cycles later.
  - HI/LO architectural update lands 3 cycles after the EX-stage value is presented.
- Back-to-back HI/LO writes: both forwarding stages are visible simultaneously. Downstream priority is mem over wb; this block does not merge them.
- whilo=0 entries: must not alter HI/LO regardless of hi/lo field contents.

Optional Feature:
- HILO_BYPASS_EN defined: hi_o/lo_o are write-through.
  - When MEM/WB whilo=1 and stall_i[5]=0, hi_o/lo_o show MEM/WB hi/lo combinationally in the same cycle; otherwise the architectural registers.
- Undefined: hi_o/lo_o come strictly from the architectural registers (1-cycle later visibility).

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 one cycle, then ex_whilo_i=1, ex_hi_i=32'h1234_5678 while rst=1.
  - Required: all outputs 0; HI stays 0.
- Single MTHI-style write:
  - Stimulus: ex_whilo_i=1, hi=32'hDEAD_BEEF, lo=32'h0000_0001 for 1 cycle.
  - Required: mem_hi_o valid at +1, wb_hi_o at +2, hi_o=32'hDEAD_BEEF / lo_o=1 at +3 (at +2 with HILO_BYPASS_EN).
- Back-to-back writes:
  - Stimulus: hi=A then hi=B on consecutive cycles.
  - Required: one cycle with mem_hi_o=B and wb_hi_o=A, both whilo=1; final hi_o=B.
- Stall bubble:
  - Stimulus: stall_i=6'b001000 with a GPR write in EX.
  - Required: EX/MEM becomes bubble (mem_whilo_o=0); rf_we_o never pulses for that instruction until stall releases and EX re-presents it.
- Flush:
  - Stimulus: flush_i=1 while EX/MEM holds whilo=1 and MEM/WB holds whilo=1, hi=32'h55.
  - Required: hi_o becomes 32'h55; the EX/MEM entry is discarded; both stage registers read 0 next cycle.
- WB stall:
  - Stimulus: stall_i[5]=1 with MEM/WB whilo=1, wreg=1.
  - Required: rf_we_o=0, HI/LO unchanged, MEM/WB held; commit occurs on the first cycle stall_i[5]=0.

Source files
------------

// File: rtl/hilo_commit_pipe_if.sv
// Execute-stage result and HI/LO write bus feeding hilo_commit_pipe.
// The master side is the execute stage; the slave side is the commit pipe.
interface hilo_commit_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ex_wd_i;
  logic              ex_wreg_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              ex_whilo_i;
  logic [DATA_W-1:0] ex_hi_i;
  logic [DATA_W-1:0] ex_lo_i;

  modport master (
    output ex_wd_i, ex_wreg_i, ex_wdata_i, ex_whilo_i, ex_hi_i, ex_lo_i
  );

  modport slave (
    input  ex_wd_i, ex_wreg_i, ex_wdata_i, ex_whilo_i, ex_hi_i, ex_lo_i
  );
endinterface

// File: rtl/hilo_commit_pipe.sv
// EX/MEM and MEM/WB pipeline registers plus architectural HI/LO, with forwarding taps.
// Optional macro HILO_BYPASS_EN: hi_o/lo_o become write-through from the MEM/WB stage.
module hilo_commit_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  hilo_commit_pipe_if.slave ex,
  output logic              mem_whilo_o,
  output logic [DATA_W-1:0] mem_hi_o,
  output logic [DATA_W-1:0] mem_lo_o,
  output logic              wb_whilo_o,
  output logic [DATA_W-1:0] wb_hi_o,
  output logic [DATA_W-1:0] wb_lo_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } stage_t;

  stage_t            ex_stage;
  stage_t            ex_mem_d, ex_mem_q;
  stage_t            mem_wb_d, mem_wb_q;
  logic [DATA_W-1:0] hi_d, hi_q;
  logic [DATA_W-1:0] lo_d, lo_q;
  logic              commit;

  always_comb begin
    ex_stage.wd    = ex.ex_wd_i;
    ex_stage.wreg  = ex.ex_wreg_i;
    ex_stage.wdata = ex.ex_wdata_i;
    ex_stage.whilo = ex.ex_whilo_i;
    ex_stage.hi    = ex.ex_hi_i;
    ex_stage.lo    = ex.ex_lo_i;
  end

  // A stage whose producer is stopped but whose own stage runs takes a bubble.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    ex_mem_d = ex_mem_q;
    mem_wb_d = mem_wb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    if (flush_i)                       ex_mem_d = '0;
    else if (stall_i[3] && !stall_i[4]) ex_mem_d = '0;
    else if (!stall_i[3])              ex_mem_d = ex_stage;

    if (flush_i)                       mem_wb_d = '0;
    else if (stall_i[4] && !stall_i[5]) mem_wb_d = '0;
    else if (!stall_i[4])              mem_wb_d = ex_mem_q;

    // The WB instruction retires even during a flush.
    commit = mem_wb_q.whilo && !stall_i[5];
    if (commit) begin
      hi_d = mem_wb_q.hi;
      lo_d = mem_wb_q.lo;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
    if (rst) begin
      ex_mem_q <= '0;
      mem_wb_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign mem_whilo_o = ex_mem_q.whilo;
  assign mem_hi_o    = ex_mem_q.hi;
  assign mem_lo_o    = ex_mem_q.lo;
  assign wb_whilo_o  = mem_wb_q.whilo;
  assign wb_hi_o     = mem_wb_q.hi;
  assign wb_lo_o     = mem_wb_q.lo;
  assign rf_we_o     = mem_wb_q.wreg && !stall_i[5];
  assign rf_waddr_o  = mem_wb_q.wd;
  assign rf_wdata_o  = mem_wb_q.wdata;

`ifdef HILO_BYPASS_EN
  assign hi_o = commit ? mem_wb_q.hi : hi_q;
  assign lo_o = commit ? mem_wb_q.lo : lo_q;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

endmodule

// File: tb/tb_hilo_commit_pipe.sv
// Directed bench for hilo_commit_pipe: expected RF writes and HI/LO commits are
// queued at issue time and matched by a negedge monitor; stage taps are checked directly.
module tb_hilo_commit_pipe;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [5:0]        stall_i;
  logic              flush_i;
  logic              mem_whilo_o, wb_whilo_o, rf_we_o;
  logic [DATA_W-1:0] mem_hi_o, mem_lo_o, wb_hi_o, wb_lo_o, rf_wdata_o, hi_o, lo_o;
  logic [ADDR_W-1:0] rf_waddr_o;

  hilo_commit_pipe_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ex_if ();

  hilo_commit_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .ex          (ex_if.slave),
    .mem_whilo_o (mem_whilo_o),
    .mem_hi_o    (mem_hi_o),
    .mem_lo_o    (mem_lo_o),
    .wb_whilo_o  (wb_whilo_o),
    .wb_hi_o     (wb_hi_o),
    .wb_lo_o     (wb_lo_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W+DATA_W-1:0] rf_q[$];
  logic [2*DATA_W-1:0]      hilo_q[$];
  logic [2*DATA_W-1:0]      hilo_pend;
  logic                     hilo_pend_v = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_if.ex_wd_i    = '0;
    ex_if.ex_wreg_i  = 1'b0;
    ex_if.ex_wdata_i = '0;
    ex_if.ex_whilo_i = 1'b0;
    ex_if.ex_hi_i    = '0;
    ex_if.ex_lo_i    = '0;
  endtask

  // Present one instruction in EX; only instructions that will retire queue expectations.
  task automatic issue(input logic [ADDR_W-1:0] wd, input logic wreg,
                       input logic [DATA_W-1:0] wdata, input logic whilo,
                       input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo,
                       input logic retires);
    ex_if.ex_wd_i    = wd;
    ex_if.ex_wreg_i  = wreg;
    ex_if.ex_wdata_i = wdata;
    ex_if.ex_whilo_i = whilo;
    ex_if.ex_hi_i    = hi;
    ex_if.ex_lo_i    = lo;
    if (retires && wreg)  rf_q.push_back({wd, wdata});
    if (retires && whilo) hilo_q.push_back({hi, lo});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_whilo"}, {31'd0, mem_whilo_o}, 32'd0);
    check({tag, "_mem_hi"}, mem_hi_o, 32'd0);
    check({tag, "_wb_whilo"}, {31'd0, wb_whilo_o}, 32'd0);
    check({tag, "_wb_hi"}, wb_hi_o, 32'd0);
    check({tag, "_rf_we"}, {31'd0, rf_we_o}, 32'd0);
    check({tag, "_hi"}, hi_o, 32'd0);
    check({tag, "_lo"}, lo_o, 32'd0);
  endtask

  // Monitor: RF writes and HI/LO commits are compared against the queues.
  always @(negedge clk) begin
    logic [2*DATA_W-1:0]      e;
    logic [ADDR_W+DATA_W-1:0] r;
    if (hilo_pend_v) begin
      check("commit_hi", hi_o, hilo_pend[2*DATA_W-1:DATA_W]);
      check("commit_lo", lo_o, hilo_pend[DATA_W-1:0]);
      hilo_pend_v = 1'b0;
    end
    if (!rst && wb_whilo_o && !stall_i[5]) begin
      if (hilo_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_hilo_commit: hi %h lo %h, none expected", wb_hi_o, wb_lo_o);
      end else begin
        e = hilo_q.pop_front();
`ifdef HILO_BYPASS_EN
        check("bypass_hi", hi_o, e[2*DATA_W-1:DATA_W]);
        check("bypass_lo", lo_o, e[DATA_W-1:0]);
`else
        hilo_pend   = e;
        hilo_pend_v = 1'b1;
`endif
      end
    end
    if (rf_we_o) begin
      if (rf_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rf_write: addr %0d data %h, none expected", rf_waddr_o, rf_wdata_o);
      end else begin
        r = rf_q.pop_front();
        check("rf_waddr", {27'd0, rf_waddr_o}, {27'd0, r[ADDR_W+DATA_W-1:DATA_W]});
        check("rf_wdata", rf_wdata_o, r[DATA_W-1:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_i = '0; flush_i = 1'b0;
    idle();
    // Reset with a HI/LO write sitting in EX.
    ex_if.ex_whilo_i = 1'b1;
    ex_if.ex_hi_i    = 32'h1234_5678;
    tick();
    check_all_zero("rst1");
    tick();
    check_all_zero("rst2");
    rst = 1'b0;
    idle();
    tick();
    check_all_zero("idle");

    // Single MTHI-style write.
    issue(5'd0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1);
    tick();
    idle();
    check("single_mem_whilo", {31'd0, mem_whilo_o}, 32'd1);
    check("single_mem_hi", mem_hi_o, 32'hDEAD_BEEF);
    check("single_hi_p1", hi_o, 32'd0);
    tick();
    check("single_wb_hi", wb_hi_o, 32'hDEAD_BEEF);
    check("single_wb_lo", wb_lo_o, 32'h0000_0001);
`ifdef HILO_BYPASS_EN
    check("single_hi_p2", hi_o, 32'hDEAD_BEEF);
`else
    check("single_hi_p2", hi_o, 32'd0);
`endif
    tick();
    check("single_hi_p3", hi_o, 32'hDEAD_BEEF);
    check("single_lo_p3", lo_o, 32'h0000_0001);

    // Back-to-back writes; B also writes GPR 5.
    issue(5'd0, 1'b0, 32'd0, 1'b1, 32'hAAAA_0001, 32'hAAAA_1001, 1'b1);
    tick();
    issue(5'd5, 1'b1, 32'h0000_0505, 1'b1, 32'hBBBB_0002, 32'hBBBB_1002, 1'b1);
    tick();
    idle();
    check("b2b_mem_hi", mem_hi_o, 32'hBBBB_0002);
    check("b2b_wb_hi", wb_hi_o, 32'hAAAA_0001);
    check("b2b_both_whilo", {30'd0, mem_whilo_o, wb_whilo_o}, 32'd3);
    tick();
    tick();
    check("b2b_final_hi", hi_o, 32'hBBBB_0002);
    check("b2b_final_lo", lo_o, 32'hBBBB_1002);

    // whilo=0 entry with garbage hi/lo; boundary GPR address and data.
    issue(5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    tick();
    idle();
    tick();
    tick();
    tick();
    check("nowhilo_hi", hi_o, 32'hBBBB_0002);
    check("nowhilo_lo", lo_o, 32'hBBBB_1002);

    // EX stall: EX/MEM takes bubbles until the stall releases.
    issue(5'd7, 1'b1, 32'h0000_0077, 1'b1, 32'h0000_7070, 32'h0000_0707, 1'b1);
    stall_i = 6'b001000;
    tick();
    check("stall_mem_whilo", {31'd0, mem_whilo_o}, 32'd0);
    check("stall_mem_hi", mem_hi_o, 32'd0);
    tick();
    check("stall_mem_whilo2", {31'd0, mem_whilo_o}, 32'd0);
    stall_i = 6'b000000;
    tick();
    idle();
    check("stall_rel_mem_whilo", {31'd0, mem_whilo_o}, 32'd1);
    check("stall_rel_mem_hi", mem_hi_o, 32'h0000_7070);
    tick();
    tick();
    check("stall_final_hi", hi_o, 32'h0000_7070);

    // Flush: WB entry commits, EX/MEM entry is discarded.
    issue(5'd0, 1'b0, 32'd0, 1'b1, 32'h0000_0055, 32'h0000_0056, 1'b1);
    tick();
    issue(5'd9, 1'b1, 32'h0000_0999, 1'b1, 32'h0000_0099, 32'h0000_0098, 1'b0);
    tick();
    idle();
    check("flush_pre_mem_hi", mem_hi_o, 32'h0000_0099);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_hi", hi_o, 32'h0000_0055);
    check("flush_lo", lo_o, 32'h0000_0056);
    check("flush_mem_whilo", {31'd0, mem_whilo_o}, 32'd0);
    check("flush_mem_hi", mem_hi_o, 32'd0);
    check("flush_wb_whilo", {31'd0, wb_whilo_o}, 32'd0);
    check("flush_wb_hi", wb_hi_o, 32'd0);
    tick();
    tick();

    // WB stall: MEM/WB holds, no RF write or commit until release.
    issue(5'd12, 1'b1, 32'h0000_C0DE, 1'b1, 32'h1111_2222, 32'h3333_4444, 1'b1);
    tick();
    idle();
    tick();
    stall_i = 6'b111000;
    #1;
    check("wbstall_rf_we", {31'd0, rf_we_o}, 32'd0);
    check("wbstall_hi0", hi_o, 32'h0000_0055);
    tick();
    tick();
    check("wbstall_wb_whilo", {31'd0, wb_whilo_o}, 32'd1);
    check("wbstall_wb_hi", wb_hi_o, 32'h1111_2222);
    check("wbstall_rf_we2", {31'd0, rf_we_o}, 32'd0);
    check("wbstall_hi", hi_o, 32'h0000_0055);
    stall_i = 6'b000000;
    tick();
    check("wbstall_rel_hi", hi_o, 32'h1111_2222);
    check("wbstall_rel_lo", lo_o, 32'h3333_4444);
    check("wbstall_rel_wb_whilo", {31'd0, wb_whilo_o}, 32'd0);

    // Reset mid-operation discards the in-flight entry and clears HI/LO.
    issue(5'd1, 1'b1, 32'h0000_0BAD, 1'b1, 32'h0000_BAD0, 32'h0000_BAD1, 1'b0);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    tick();
    tick();
    tick();
    check_all_zero("post_rst");

    check("rf_queue_drained", rf_q.size(), 32'd0);
    check("hilo_queue_drained", hilo_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
